axil_app_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the user-side application port of `axis_lite_m` between `NUM_REQ` independent requesters. Each requester posts a single read or write, and the block serialises them onto `app_wen`/`app_ren`. It waits for the master's completion and routes `app_rdata` and the error status back to the originating requester. It sits between the client logic and `axis_lite_m`; the AXI-Lite channels themselves are not touched.

---
 rtl/axil_app_arbiter.sv | 154 +++++++++++++++
 tb/tb_axil_app_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_app_arbiter.sv
// Round-robin arbiter that serialises single read/write requests from NUM_REQ
// clients onto the application port of axis_lite_m and routes completions back.
module axil_app_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                        aclk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_error,
    output logic                        busy,
    output logic [ADDR_W-1:0]           app_waddr,
    output logic [DATA_W-1:0]           app_wdata,
    output logic                        app_wen,
    input  logic                        app_wdone,
    input  logic                        app_werror,
    output logic [ADDR_W-1:0]           app_raddr,
    output logic                        app_ren,
    input  logic [DATA_W-1:0]           app_rdata,
    input  logic                        app_rdone,
    input  logic                        app_rerror
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                wdone_q, rdone_q;

    logic                found;
    logic [IDX_W-1:0]    sel;
    logic [IDX_W-1:0]    cand_idx;
    int unsigned         cand;

    // Rotating priority: scan starting just after the last served requester.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand     = (int'(last_grant_q) + 1 + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req_valid[cand_idx]) begin
                found = 1'b1;
                sel   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        req_ready    = '0;
        rsp_valid    = '0;
        app_wen      = 1'b0;
        app_ren      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Gated by reset so a request cannot see an accept that is never captured.
                if (found && !reset) begin
                    req_ready[sel] = 1'b1;
                    grant_d        = sel;
                    write_d        = req_write[sel];
                    addr_d         = req_addr[int'(sel)*ADDR_W +: ADDR_W];
                    wdata_d        = req_wdata[int'(sel)*DATA_W +: DATA_W];
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                app_wen = write_q;
                app_ren = !write_q;
                state_d = WAIT;
            end
            WAIT: begin
                if (write_q && app_wdone && !wdone_q) begin
                    err_d   = app_werror;
                    rdata_d = '0;
                    state_d = RESP;
                end else if (!write_q && app_rdone && !rdone_q) begin
                    err_d   = app_rerror;
                    rdata_d = app_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                last_grant_d       = grant_q;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            grant_q      <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            wdone_q      <= 1'b0;
            rdone_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            wdone_q      <= app_wdone;
            rdone_q      <= app_rdone;
        end
    end

    assign busy      = (state_q != IDLE);
    assign app_waddr = addr_q;
    assign app_raddr = addr_q;
    assign app_wdata = wdata_q;
    assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
    assign rsp_error = (state_q == RESP) ? err_q : 1'b0;

endmodule

// File: tb/tb_axil_app_arbiter.sv
// Directed bench for axil_app_arbiter: the bench plays the master side of the
// application port and checks grants, issue pulses and completion routing.
module tb_axil_app_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic              aclk;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_error;
    logic              busy;
    logic [AW-1:0]     app_waddr;
    logic [DW-1:0]     app_wdata;
    logic              app_wen;
    logic              app_wdone;
    logic              app_werror;
    logic [AW-1:0]     app_raddr;
    logic              app_ren;
    logic [DW-1:0]     app_rdata;
    logic              app_rdone;
    logic              app_rerror;

    int checks = 0;
    int errors = 0;

    axil_app_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .aclk       (aclk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .busy       (busy),
        .app_waddr  (app_waddr),
        .app_wdata  (app_wdata),
        .app_wen    (app_wen),
        .app_wdone  (app_wdone),
        .app_werror (app_werror),
        .app_raddr  (app_raddr),
        .app_ren    (app_ren),
        .app_rdata  (app_rdata),
        .app_rdone  (app_rdone),
        .app_rerror (app_rerror)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic post(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]           = 1'b1;
        req_write[i]           = wr;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    // Entered in the accept cycle; returns in the following IDLE cycle.
    task automatic run_txn(input int g, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] rd, input logic err,
                           input logic drop, input logic hold);
        tick();
        if (drop) req_valid[g] = 1'b0;
        #1;
        chk("issue_wen", app_wen, wr);
        chk("issue_ren", app_ren, !wr);
        chk("issue_addr", wr ? app_waddr : app_raddr, addr);
        chk("issue_ready", req_ready, 0);
        chk("issue_busy", busy, 1);
        tick();
        #1;
        chk("wait_wen", app_wen | app_ren, 0);
        chk("wait_rsp", rsp_valid, 0);
        if (wr) begin
            app_wdone  = 1'b1;
            app_werror = err;
        end else begin
            app_rdone  = 1'b1;
            app_rerror = err;
            app_rdata  = rd;
        end
        tick();
        if (!hold) app_wdone = 1'b0;
        app_rdone  = 1'b0;
        app_werror = 1'b0;
        app_rerror = 1'b0;
        #1;
        chk("rsp_valid", rsp_valid, 64'(1) << g);
        chk("rsp_error", rsp_error, err);
        chk("rsp_rdata", rsp_rdata, wr ? 32'h0 : rd);
        chk("rsp_busy", busy, 1);
        tick();
        #1;
        chk("idle_rsp", rsp_valid, 0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        app_wdone  = 1'b0;
        app_werror = 1'b0;
        app_rdata  = '0;
        app_rdone  = 1'b0;
        app_rerror = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_outs", {app_wen, app_ren, rsp_valid, rsp_error, req_ready}, 0);
        chk("rst_addr", {app_waddr, app_raddr}, 0);
        reset = 1'b0;
        tick();

        // Single write on requester 1
        post(1, 1'b1, 32'h1010_1111, 32'h1010_1111);
        #1;
        chk("w1_ready", req_ready, 4'b0010);
        chk("w1_busy", busy, 0);
        run_txn(1, 1'b1, 32'h1010_1111, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("w1_wdata_held", app_wdata, 32'h1010_1111);

        // Single read on requester 2
        post(2, 1'b0, 32'haaaa_bbbb, 32'h0);
        #1;
        chk("r2_ready", req_ready, 4'b0100);
        run_txn(2, 1'b0, 32'haaaa_bbbb, 32'haaaa_bbbb, 1'b0, 1'b1, 1'b0);

        // Reset, then all four requesters at once
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) post(k, 1'b1, 32'h100 + k, 32'h200 + k);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", req_ready, 64'(1) << k);
            run_txn(k, 1'b1, 32'h100 + k, 32'h0, 1'b0, 1'b1, 1'b0);
        end

        // Requesters 0 and 2 request continuously
        post(0, 1'b1, 32'h300, 32'h0);
        post(2, 1'b1, 32'h302, 32'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("alt_ready", req_ready, (k % 2 == 0) ? 4'b0001 : 4'b0100);
            run_txn((k % 2 == 0) ? 0 : 2, 1'b1, (k % 2 == 0) ? 32'h300 : 32'h302,
                    32'h0, 1'b0, 1'b0, 1'b0);
        end
        req_valid = '0;

        // Write error on requester 3 with a spurious read done in WAIT
        post(3, 1'b1, 32'h4444_0000, 32'h1234);
        #1;
        chk("e3_ready", req_ready, 4'b1000);
        tick();
        req_valid[3] = 1'b0;
        #1;
        chk("e3_wen", app_wen, 1);
        tick();
        app_rdone = 1'b1;
        tick();
        app_rdone = 1'b0;
        #1;
        chk("e3_spurious_rsp", rsp_valid, 0);
        chk("e3_busy", busy, 1);
        tick();
        app_wdone  = 1'b1;
        app_werror = 1'b1;
        #1;
        chk("e3_pre_rsp", rsp_valid, 0);
        tick();
        app_wdone  = 1'b0;
        app_werror = 1'b0;
        #1;
        chk("e3_rsp_valid", rsp_valid, 4'b1000);
        chk("e3_rsp_error", rsp_error, 1);
        tick();

        // Reset while WAITing on a requester 1 read
        post(1, 1'b0, 32'h5555_0000, 32'h0);
        #1;
        chk("rw_ready", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        #1;
        chk("rw_ren", app_ren, 1);
        tick();
        reset = 1'b1;
        #1;
        chk("rw_rst_rsp", rsp_valid, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("rw_after_busy", busy, 0);
        chk("rw_after_outs", {app_wen, app_ren, rsp_valid, rsp_error, req_ready}, 0);
        chk("rw_after_addr", {app_waddr, app_raddr, app_wdata, rsp_rdata}, 0);
        post(0, 1'b1, 32'h6000, 32'h1);
        post(1, 1'b1, 32'h6001, 32'h2);
        #1;
        chk("rw_first", req_ready, 4'b0001);
        run_txn(0, 1'b1, 32'h6000, 32'h0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("rw_second", req_ready, 4'b0010);
        run_txn(1, 1'b1, 32'h6001, 32'h0, 1'b0, 1'b1, 1'b0);

        // Write done held high into the next write
        post(2, 1'b1, 32'h7002, 32'h0);
        #1;
        chk("sd_ready2", req_ready, 4'b0100);
        run_txn(2, 1'b1, 32'h7002, 32'h0, 1'b0, 1'b1, 1'b1);
        post(3, 1'b1, 32'h7003, 32'h0);
        #1;
        chk("sd_ready3", req_ready, 4'b1000);
        tick();
        req_valid[3] = 1'b0;
        #1;
        chk("sd_wen", app_wen, 1);
        tick();
        #1;
        chk("sd_wait1", rsp_valid, 0);
        tick();
        #1;
        chk("sd_wait2", rsp_valid, 0);
        app_wdone = 1'b0;
        tick();
        #1;
        chk("sd_wait3", rsp_valid, 0);
        app_wdone = 1'b1;
        tick();
        app_wdone = 1'b0;
        #1;
        chk("sd_rsp", rsp_valid, 4'b1000);
        tick();
        #1;
        chk("sd_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
